// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//  Shared definitions for the mux_n_1_tdm block: mode encodings for Mode_In,
//  the controller state encoding and the default widths used by the top.
//  No ports (package).
// ----------------------------------------------------------------------------
package mux_pkg;

    // Mode_In encodings
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } mux_state_e;

    // Default geometry
    localparam int DEF_NUM_CH  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DWELL_W = 8;

endpackage

// File: rtl/mux_rr_next_channel.sv
// ----------------------------------------------------------------------------
// mux_rr_next_channel
//  Combinational round-robin helper. Given the channel mask and the current
//  scan pointer, returns the next enabled channel strictly above the pointer,
//  wrapping to the lowest enabled channel when none is above.
//
//  Ports
//   i_mask  in   NUM_CH  channel enable mask (bit i = channel i)
//   i_ptr   in   SEL_W   current pointer
//   o_next  out  SEL_W   next enabled index (== i_ptr when mask is zero)
//   o_wrap  out  1       next index <= current (search wrapped around)
//   o_any   out  1       at least one channel enabled
// ----------------------------------------------------------------------------
module mux_rr_next_channel #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_wrap,
    output logic              o_any
);

    logic [SEL_W-1:0] w_above;
    logic [SEL_W-1:0] w_lowest;
    logic             w_have_above;

    // Both searches run downward so the last hit is the lowest qualifying index.
    always_comb begin
        w_above      = '0;
        w_lowest     = '0;
        w_have_above = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_lowest = SEL_W'(i);
                if (SEL_W'(i) > i_ptr) begin
                    w_above      = SEL_W'(i);
                    w_have_above = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_any  = |i_mask;
        o_next = i_ptr;
        o_wrap = 1'b0;
        if (o_any) begin
            o_next = w_have_above ? w_above : w_lowest;
            // A lone enabled channel resolves to itself, which counts as a wrap.
            o_wrap = !w_have_above;
        end
    end

endmodule

// File: rtl/mux_n_1_tdm.sv
// ----------------------------------------------------------------------------
// mux_n_1_tdm
//  Registered N:1 multiplexer with a valid/ready output slice. DIRECT mode
//  forwards the host-selected channel; SCAN mode walks the masked channels
//  round-robin, staying Dwell_In+1 accepted transfers on each.
//
//  Ports
//   Clock_In         in   1              rising-edge clock
//   Reset_n_In       in   1              asynchronous active-low reset
//   Enable_In        in   1              block enable (low -> IDLE, output dropped)
//   Mode_In          in   1              MODE_DIRECT / MODE_SCAN
//   Select_In        in   SEL_W          DIRECT channel index
//   Channel_Mask_In  in   NUM_CH         SCAN channel enables
//   Dwell_In         in   DWELL_W        SCAN transfers per channel minus one
//   Data_In          in   NUM_CH*DATA_W  flattened channel data
//   Mux_Ready_In     in   1              consumer ready
//   Mux_Data_Out     out  DATA_W         registered data
//   Mux_Channel_Out  out  SEL_W          channel of Mux_Data_Out
//   Mux_Valid_Out    out  1              Mux_Data_Out valid
//   Scan_Wrap_Out    out  1              one-cycle pulse on SCAN pointer wrap
//
//  SEL_W may be set wider than $clog2(NUM_CH) so that out-of-range DIRECT
//  selects are representable; such selects load zero data.
// ----------------------------------------------------------------------------
module mux_n_1_tdm
    import mux_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = $clog2(NUM_CH),
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic                     Clock_In,
    input  logic                     Reset_n_In,
    input  logic                     Enable_In,
    input  logic                     Mode_In,
    input  logic [SEL_W-1:0]         Select_In,
    input  logic [NUM_CH-1:0]        Channel_Mask_In,
    input  logic [DWELL_W-1:0]       Dwell_In,
    input  logic [NUM_CH*DATA_W-1:0] Data_In,
    input  logic                     Mux_Ready_In,
    output logic [DATA_W-1:0]        Mux_Data_Out,
    output logic [SEL_W-1:0]         Mux_Channel_Out,
    output logic                     Mux_Valid_Out,
    output logic                     Scan_Wrap_Out
);

    mux_state_e         r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_wrap;
    logic [DATA_W-1:0]  r_data;
    logic [SEL_W-1:0]   r_chan;
    logic               r_valid;

    logic               w_open, w_hs, w_hs_scan;
    logic               w_scan_go, w_enter;
    logic [SEL_W-1:0]   w_low, w_eff_ptr, w_next, w_load_ptr;
    logic [DWELL_W-1:0] w_eff_cnt;
    logic               w_ptr_en, w_any, w_wrap;
    logic               w_advance, w_relocate;
    logic [DATA_W-1:0]  w_dir_data, w_scan_data;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!Enable_In)                 w_state_nxt = ST_IDLE;
        else if (Mode_In == MODE_DIRECT) w_state_nxt = ST_DIRECT;
        else                            w_state_nxt = ST_SCAN;
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_open = !r_valid || Mux_Ready_In;
    assign w_hs   = r_valid && Mux_Ready_In;

    // ------------------------------------------------------------------
    // Scan pointer / dwell bookkeeping
    //  The cycle that enters SCAN works from a fresh pointer (lowest enabled
    //  channel, count 0), so the load in that same cycle already comes from
    //  it. An acceptance in the entry cycle belongs to the previous mode's
    //  word and is not counted.
    // ------------------------------------------------------------------
    assign w_scan_go = Enable_In && (Mode_In == MODE_SCAN);
    assign w_enter   = w_scan_go && (r_state != ST_SCAN);
    assign w_hs_scan = w_hs && !w_enter;

    always_comb begin
        w_low = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (Channel_Mask_In[i]) w_low = SEL_W'(i);
        end
    end

    assign w_eff_ptr = w_enter ? w_low : r_ptr;
    assign w_eff_cnt = w_enter ? '0    : r_cnt;

    always_comb begin
        w_ptr_en = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_eff_ptr == SEL_W'(i)) w_ptr_en = Channel_Mask_In[i];
        end
    end

    mux_rr_next_channel #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next (
        .i_mask (Channel_Mask_In),
        .i_ptr  (w_eff_ptr),
        .o_next (w_next),
        .o_wrap (w_wrap),
        .o_any  (w_any)
    );

    // ">=" so a Dwell_In lowered below the running count ends the dwell at
    // the next acceptance.
    assign w_advance  = w_scan_go && w_ptr_en && w_hs_scan && (w_eff_cnt >= Dwell_In);
    assign w_relocate = w_scan_go && !w_ptr_en && w_any;

    // When the word being accepted completes the dwell, the replacement word
    // already comes from the next channel, so each channel gets exactly
    // Dwell_In+1 transfers under continuous ready.
    assign w_load_ptr = w_advance ? w_next : w_eff_ptr;

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_scan_go) begin
                if (w_relocate || w_advance) begin
                    r_ptr  <= w_next;
                    r_cnt  <= '0;
                    r_wrap <= w_wrap;
                end else begin
                    r_ptr <= w_eff_ptr;
                    r_cnt <= (w_ptr_en && w_hs_scan) ? w_eff_cnt + DWELL_W'(1) : w_eff_cnt;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Data selection
    // ------------------------------------------------------------------
    always_comb begin
        w_dir_data  = '0;
        w_scan_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Select_In == SEL_W'(i))  w_dir_data  = Data_In[i*DATA_W +: DATA_W];
            if (w_load_ptr == SEL_W'(i)) w_scan_data = Data_In[i*DATA_W +: DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // Output register slice
    //  Disable drops the word even if unacknowledged; data/channel keep
    //  their last value while Valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else if (!Enable_In) begin
            r_valid <= 1'b0;
        end else if (w_open) begin
            if (Mode_In == MODE_DIRECT) begin
                r_data  <= w_dir_data;
                r_chan  <= Select_In;
                r_valid <= 1'b1;
            end else if (w_ptr_en) begin
                r_data  <= w_scan_data;
                r_chan  <= w_load_ptr;
                r_valid <= 1'b1;
            end else begin
                // Pointer channel disabled (or empty mask): bubble.
                r_valid <= 1'b0;
            end
        end
    end

    assign Mux_Data_Out    = r_data;
    assign Mux_Channel_Out = r_chan;
    assign Mux_Valid_Out   = r_valid;
    assign Scan_Wrap_Out   = r_wrap;

endmodule

// File: tb/tb_mux_n_1_tdm.sv
module tb_mux_n_1_tdm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, mode, rdy;
    logic [3:0]  sel;
    logic [7:0]  mask, dwell;
    logic [63:0] data_in;
    logic [7:0]  d_out;
    logic [3:0]  c_out;
    logic        v_out, w_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_n_1_tdm #(.NUM_CH(8), .DATA_W(8), .SEL_W(4), .DWELL_W(8)) dut (
        .Clock_In        (clk),
        .Reset_n_In      (rst_n),
        .Enable_In       (en),
        .Mode_In         (mode),
        .Select_In       (sel),
        .Channel_Mask_In (mask),
        .Dwell_In        (dwell),
        .Data_In         (data_in),
        .Mux_Ready_In    (rdy),
        .Mux_Data_Out    (d_out),
        .Mux_Channel_Out (c_out),
        .Mux_Valid_Out   (v_out),
        .Scan_Wrap_Out   (w_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_st, m_ptr, m_cnt, m_data, m_chan, m_valid, m_wrap;

    function automatic int next_en(input logic [7:0] m, input int p);
        for (int k = 1; k <= 8; k++) if (m[(p + k) % 8]) return (p + k) % 8;
        return p;
    endfunction

    function automatic int lowest_en(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int chan_data(input int c);
        if (c >= 8) return 0;
        return int'(data_in[c*8 +: 8]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_ptr <= 0; m_cnt <= 0;
            m_data <= 0; m_chan <= 0; m_valid <= 0; m_wrap <= 0;
        end else begin : step_model
            int p, c, np, nc, ld, nd, nch, nv, nw;
            bit hs, open, entering, scan;
            hs       = (m_valid != 0) && rdy;
            open     = (m_valid == 0) || rdy;
            scan     = en && mode;
            entering = scan && (m_st != 2);
            p  = entering ? lowest_en(mask) : m_ptr;
            c  = entering ? 0 : m_cnt;
            np = m_ptr; nc = m_cnt; nw = 0; ld = p;
            nd = m_data; nch = m_chan; nv = m_valid;
            if (scan) begin
                np = p; nc = c;
                if (!mask[p] && mask != 0) begin
                    np = next_en(mask, p); nc = 0; nw = (np <= p) ? 1 : 0;
                end else if (mask[p] && hs && !entering) begin
                    if (c >= int'(dwell)) begin
                        np = next_en(mask, p); nc = 0; nw = (np <= p) ? 1 : 0; ld = np;
                    end else nc = c + 1;
                end
            end
            if (!en) nv = 0;
            else if (open) begin
                if (!mode) begin nv = 1; nch = int'(sel); nd = chan_data(int'(sel)); end
                else if (mask[p]) begin nv = 1; nch = ld; nd = chan_data(ld); end
                else nv = 0;
            end
            m_st <= !en ? 0 : (mode ? 2 : 1);
            m_ptr <= np; m_cnt <= nc; m_wrap <= nw;
            m_data <= nd; m_chan <= nch; m_valid <= nv;
        end
    end

    // compare process: every cycle
    always @(negedge clk) begin
        chk("model_valid", int'(v_out), m_valid);
        chk("model_data",  int'(d_out), m_data);
        chk("model_chan",  int'(c_out), m_chan);
        chk("model_wrap",  int'(w_out), m_wrap);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    int exp_seq[8] = '{0, 0, 2, 2, 5, 5, 7, 7};
    int exp5[5]    = '{2, 2, 2, 2, 5};
    int wraps;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; rdy = 1'b1;
        sel = 4'd0; mask = 8'h00; dwell = 8'd0;
        for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = 8'(8'hA0 + i);

        step(2);
        chk("reset_valid", int'(v_out), 0);
        chk("reset_wrap",  int'(w_out), 0);
        rst_n = 1'b1;
        step(1);

        // DIRECT select 5
        en = 1'b1; sel = 4'd5;
        step(1);
        chk("direct_valid", int'(v_out), 1);
        chk("direct_data",  int'(d_out), 8'hA5);
        chk("direct_chan",  int'(c_out), 5);

        // DIRECT hold under backpressure
        sel = 4'd2;
        step(1);
        chk("hold_pre_chan", int'(c_out), 2);
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sel = 4'(3 + k);
            step(1);
            chk("hold_chan", int'(c_out), 2);
            chk("hold_data", int'(d_out), 8'hA2);
        end
        rdy = 1'b1;
        step(1);
        chk("release_chan", int'(c_out), 6);
        chk("release_data", int'(d_out), 8'hA6);

        // Disable drops unacknowledged word; out-of-range select
        rdy = 1'b0; en = 1'b0;
        step(1);
        chk("disable_valid", int'(v_out), 0);
        en = 1'b1; sel = 4'd9; rdy = 1'b1;
        step(1);
        chk("oor_valid", int'(v_out), 1);
        chk("oor_data",  int'(d_out), 0);
        chk("oor_chan",  int'(c_out), 9);

        // SCAN mask A5 dwell 1
        mode = 1'b1; mask = 8'hA5; dwell = 8'd1;
        step(1);
        wraps = 0;
        for (int k = 0; k < 24; k++) begin
            chk("scan_seq", int'(c_out), exp_seq[k % 8]);
            wraps += int'(w_out);
            step(1);
        end
        chk("scan_wraps", wraps, 2);

        // SCAN: current channel disabled mid-dwell
        en = 1'b0;
        step(1);
        mask = 8'hA5; dwell = 8'd3; en = 1'b1;
        step(2);
        chk("mid_chan0", int'(c_out), 0);
        mask = 8'hA4;
        step(1);
        chk("reloc_bubble", int'(v_out), 0);
        chk("reloc_wrap",   int'(w_out), 0);
        step(1);
        for (int k = 0; k < 5; k++) begin
            chk("reloc_seq", int'(c_out), exp5[k]);
            step(1);
        end

        // Empty mask: pending word held until accepted, then no loads
        rdy = 1'b0; mask = 8'h00;
        step(2);
        chk("empty_pending", int'(v_out), 1);
        rdy = 1'b1;
        step(1);
        chk("empty_drop", int'(v_out), 0);
        step(2);
        chk("empty_idle", int'(v_out), 0);

        // Async reset mid-SCAN with Valid=1
        mask = 8'hA5;
        step(3);
        chk("prereset_valid", int'(v_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", int'(v_out), 0);
        chk("async_data",  int'(d_out), 0);
        chk("async_chan",  int'(c_out), 0);
        chk("async_wrap",  int'(w_out), 0);
        en = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("post_reset_idle", int'(v_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
